parity_frame_checker: RTL and testbench
=======================================

// Module: parity_frame_checker
// PURPOSE
//  Receive end of the parity-bit link: deserialises one frame per transfer
//  (start bit, DATA_W data bits LSB first, parity bit, stop bit), recomputes
//  parity over the data bits and compares it with the received parity bit.
//  Sits downstream of the 4-bit paritybit generator and its serialiser.
//  Reports each decoded word with a valid pulse plus parity/frame error flags.
// PARAMETERS
//  DATA_W      4   data bits per frame (>=1)
//  ODD_PARITY  0   0: even parity (XOR of data ^ parity == 0); 1: odd parity
//  CNT_W       8   width of saturating parity-error counter
// PORTS
//  clk         in   1        rising-edge clock
//  rst_n       in   1        asynchronous active-low reset
//  bit_en      in   1        sample strobe; rx_bit is sampled only when 1
//  rx_bit      in   1        serial line, idle high
//  data_out    out  DATA_W   last successfully framed word (held)
//  data_valid  out  1        1-cycle pulse: new word on data_out
//  parity_err  out  1        valid with data_valid; 1 = parity mismatch
//  frame_err   out  1        1-cycle pulse: stop bit sampled as 0
//  busy        out  1        1 while a frame is in progress (state != IDLE)
//  err_cnt     out  CNT_W    count of parity errors, saturates at all-ones
// BEHAVIOUR
//  - Reset (rst_n=0, async): state=IDLE; data_out=0, data_valid=0,
//    parity_err=0, frame_err=0, busy=0, err_cnt=0; shift reg, bit counter,
//    parity accumulator cleared. Reset mid-frame abandons the frame, no pulse.
//  - All state changes occur only on cycles with bit_en=1; with bit_en=0 all
//    registers hold, except data_valid/frame_err, which drop to 0.
//  - FSM: IDLE -> DATA when bit_en & rx_bit==0 (start bit); rx_bit==1 stays.
//    DATA: each bit_en shifts rx_bit into bit [cnt] of the shift reg,
//    XORs it into acc, cnt++; after DATA_W bits -> PARITY.
//    PARITY: on bit_en, perr = acc ^ rx_bit ^ ODD_PARITY; -> STOP.
//    STOP: on bit_en: rx_bit==1 -> data_out<=shift, data_valid<=1,
//    parity_err<=perr, err_cnt += perr (saturating); rx_bit==0 -> frame_err<=1,
//    data_out/parity_err/err_cnt unchanged. Both -> IDLE.
//  - Latency: outputs registered; data_valid/frame_err high the cycle after the
//    clk edge that samples the stop bit. Total 1+DATA_W+2 strobes per frame.
//  - Back-to-back: start bit may be on the strobe immediately after stop;
//    data_valid pulse may coincide with that start-bit sampling.
//  - parity_err holds its value between valid pulses; meaningful only with
//    data_valid. A frame error does not clear parity_err.
//  - err_cnt at 2^CNT_W-1 stays there on further parity errors.
//  - cnt width $clog2(DATA_W+1); no wrap beyond DATA_W.
//  - busy = (state != IDLE), combinational from state register.
// STRUCTURE
//  - parity_pkg: state encodings ST_IDLE/ST_DATA/ST_PARITY/ST_STOP (2-bit),
//    PAR_EVEN=0/PAR_ODD=1 constants, shared with the transmit-side serialiser.
//  - One sub-module: parity_accum (1-bit XOR accumulator with clr/en), same
//    function as the generator's XOR tree unrolled in time.
//  - FSM, shift reg, counter, error counter live in this module.
// TESTING (DATA_W=4, even parity, bit_en=1 every cycle unless noted)
//  1. rx_bit 0,1,1,0,1,1,1 (word 4'hB, parity 1, stop 1) -> data_out=4'hB,
//     data_valid pulse 1 cycle, parity_err=0, err_cnt=0.
//  2. Same frame with parity bit 0 -> data_valid pulse, data_out=4'hB,
//     parity_err=1, err_cnt=1.
//  3. Frame 4'h3 (0,1,1,0,0,0,0) with stop=0 after test 1 -> frame_err pulse,
//     no data_valid, data_out stays 4'hB, err_cnt unchanged.
//  4. rst_n low after 2 data bits, then frame 4'h6 (0,0,1,1,0,0,1) ->
//     all outputs 0 during reset, busy=0; then data_out=4'h6, parity_err=0.
//  5. bit_en high every 3rd cycle, all 16 words with correct parity,
//     back-to-back -> 16 valid pulses, data_out matches each, err_cnt=0.
//  6. CNT_W=2, 5 frames with bad parity -> err_cnt 1,2,3,3,3.

Source files
------------

// File: rtl/parity_pkg.sv
// Shared definitions for the parity-bit link (transmit serialiser and
// receive checker): frame FSM state encodings and parity-sense constants.
package parity_pkg;

  // Frame phases: idle line, data bits, parity bit, stop bit.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } state_e;

  localparam bit PAR_EVEN = 1'b0;
  localparam bit PAR_ODD  = 1'b1;

endpackage : parity_pkg

// File: rtl/parity_frame_checker_if.sv
// Bundle of the serial receive line and the decoded-word outputs of the
// parity frame checker.
//   master : drives bit_en/rx_bit, observes the decoded results
//   slave  : the checker itself
//   bit_en     sample strobe          rx_bit     serial line, idle high
//   data_out   last framed word       data_valid 1-cycle new-word pulse
//   parity_err parity mismatch flag   frame_err  1-cycle bad-stop pulse
//   busy       frame in progress      err_cnt    saturating error count
interface parity_frame_checker_if #(
  parameter int DATA_W = 4,
  parameter int CNT_W  = 8
);
  logic              bit_en;
  logic              rx_bit;
  logic [DATA_W-1:0] data_out;
  logic              data_valid;
  logic              parity_err;
  logic              frame_err;
  logic              busy;
  logic [CNT_W-1:0]  err_cnt;

  modport master (
    output bit_en, rx_bit,
    input  data_out, data_valid, parity_err, frame_err, busy, err_cnt
  );

  modport slave (
    input  bit_en, rx_bit,
    output data_out, data_valid, parity_err, frame_err, busy, err_cnt
  );
endinterface : parity_frame_checker_if

// File: rtl/parity_frame_checker_accum.sv
// parity_accum: 1-bit running XOR of the bits presented while en=1; the
// time-serial form of a parity generator's XOR tree.
//   clk, rst_n : clock, async active-low reset
//   clr        : restart accumulation at 0 (wins over en)
//   en, d      : fold d into the accumulator
//   acc        : current XOR of all bits folded since the last clr
module parity_accum (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  input  logic d,
  output logic acc
);
  logic acc_d, acc_q;

  // NOTE: combinational blocks assign a default before any branch so no
  // path leaves the signal unassigned, which would infer a latch.
  always_comb begin
    acc_d = acc_q;
    if (clr)     acc_d = 1'b0;
    else if (en) acc_d = acc_q ^ d;
  end

  // NOTE: flops use non-blocking assignment so every register samples its
  // inputs from the same pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) acc_q <= 1'b0;
    else        acc_q <= acc_d;
  end

  assign acc = acc_q;
endmodule : parity_accum

// File: rtl/parity_frame_checker.sv
// parity_frame_checker: receive end of the parity-bit link. Deserialises
// start bit, DATA_W data bits (LSB first), parity bit and stop bit, checks
// the parity and reports the word with a valid pulse and error flags.
//   clk, rst_n : clock, async active-low reset
//   bus        : slave side of parity_frame_checker_if (bit_en, rx_bit in;
//                data_out, data_valid, parity_err, frame_err, busy,
//                err_cnt out)
module parity_frame_checker
  import parity_pkg::*;
#(
  parameter int DATA_W     = 4,
  parameter bit ODD_PARITY = PAR_EVEN,
  parameter int CNT_W      = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  parity_frame_checker_if.slave  bus
);
  localparam int                 BIT_CNT_W = $clog2(DATA_W + 1);
  localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(DATA_W - 1);

  state_e               state_d, state_q;
  logic [DATA_W-1:0]    shift_d, shift_q;
  logic [BIT_CNT_W-1:0] cnt_d, cnt_q;
  logic                 perr_d, perr_q;       // parity verdict awaiting stop
  logic [DATA_W-1:0]    data_d, data_q;
  logic                 valid_d, valid_q;
  logic                 parity_err_d, parity_err_q;
  logic                 frame_err_d, frame_err_q;
  logic [CNT_W-1:0]     err_cnt_d, err_cnt_q;

  logic acc_clr, acc_en, acc;

  parity_accum u_accum (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (acc_clr),
    .en    (acc_en),
    .d     (bus.rx_bit),
    .acc   (acc)
  );

  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    cnt_d        = cnt_q;
    perr_d       = perr_q;
    data_d       = data_q;
    valid_d      = 1'b0;   // pulses: high for one cycle only
    frame_err_d  = 1'b0;
    parity_err_d = parity_err_q;
    err_cnt_d    = err_cnt_q;
    acc_clr      = 1'b0;
    acc_en       = 1'b0;

    if (bus.bit_en) begin
      unique case (state_q)
        ST_IDLE: begin
          if (!bus.rx_bit) begin
            state_d = ST_DATA;
            cnt_d   = '0;
            shift_d = '0;
            acc_clr = 1'b1;
          end
        end
        ST_DATA: begin
          for (int i = 0; i < DATA_W; i++) begin
            if (cnt_q == BIT_CNT_W'(i)) shift_d[i] = bus.rx_bit;
          end
          acc_en = 1'b1;
          cnt_d  = cnt_q + BIT_CNT_W'(1);
          if (cnt_q == LAST_BIT) state_d = ST_PARITY;
        end
        ST_PARITY: begin
          perr_d  = acc ^ bus.rx_bit ^ ODD_PARITY;
          state_d = ST_STOP;
        end
        ST_STOP: begin
          if (bus.rx_bit) begin
            data_d       = shift_q;
            valid_d      = 1'b1;
            parity_err_d = perr_q;
            if (perr_q && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + CNT_W'(1);
          end else begin
            // Bad stop bit: word discarded, previous results left intact.
            frame_err_d = 1'b1;
          end
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      shift_q      <= '0;
      cnt_q        <= '0;
      perr_q       <= 1'b0;
      data_q       <= '0;
      valid_q      <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      err_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      cnt_q        <= cnt_d;
      perr_q       <= perr_d;
      data_q       <= data_d;
      valid_q      <= valid_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  assign bus.data_out   = data_q;
  assign bus.data_valid = valid_q;
  assign bus.parity_err = parity_err_q;
  assign bus.frame_err  = frame_err_q;
  assign bus.busy       = (state_q != ST_IDLE);
  assign bus.err_cnt    = err_cnt_q;
endmodule : parity_frame_checker

// File: tb/tb_parity_frame_checker.sv
// Directed bench for parity_frame_checker (DATA_W=4, even parity). A second
// instance with CNT_W=2 sees the same stimulus and is used for saturation.
module tb_parity_frame_checker;
  logic clk;
  logic rst_n;
  logic bit_en;
  logic rx_bit;

  int n_cmp = 0;
  int n_bad = 0;

  parity_frame_checker_if #(.DATA_W(4), .CNT_W(8)) bus  ();
  parity_frame_checker_if #(.DATA_W(4), .CNT_W(2)) bus2 ();

  assign bus.bit_en  = bit_en;
  assign bus.rx_bit  = rx_bit;
  assign bus2.bit_en = bit_en;
  assign bus2.rx_bit = rx_bit;

  parity_frame_checker #(.DATA_W(4), .ODD_PARITY(1'b0), .CNT_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  parity_frame_checker #(.DATA_W(4), .ODD_PARITY(1'b0), .CNT_W(2)) dut_sat (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One strobe: present the bit, take one edge, then idle `gap` cycles.
  // Returns 1 time unit after the sampling edge when gap==0.
  task automatic strobe(input logic b, input int gap);
    rx_bit = b;
    bit_en = 1'b1;
    @(posedge clk);
    #1;
    if (gap > 0) begin
      bit_en = 1'b0;
      rx_bit = 1'b1;
      repeat (gap) @(posedge clk);
      #1;
    end
  endtask

  // Sends start, data LSB first, parity; the stop bit is sampled last and
  // the task returns 1 unit after that edge with bit_en=1, rx_bit=1.
  task automatic frame(input logic [3:0] d, input logic p, input logic stop,
                       input int gap);
    strobe(1'b0, gap);
    for (int i = 0; i < 4; i++) strobe(d[i], gap);
    strobe(p, gap);
    strobe(stop, 0);
    rx_bit = 1'b1;
  endtask

  task automatic idle_cycle();
    bit_en = 1'b1;
    rx_bit = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n  = 1'b0;
    bit_en = 1'b0;
    rx_bit = 1'b1;
    #12;
    check("rst data_out",   32'(bus.data_out),   32'h0);
    check("rst data_valid", 32'(bus.data_valid), 32'h0);
    check("rst parity_err", 32'(bus.parity_err), 32'h0);
    check("rst frame_err",  32'(bus.frame_err),  32'h0);
    check("rst busy",       32'(bus.busy),       32'h0);
    check("rst err_cnt",    32'(bus.err_cnt),    32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    idle_cycle();
    check("idle busy", 32'(bus.busy), 32'h0);

    // 1: word B, correct even parity (^B = 1)
    rx_bit = 1'b0;
    bit_en = 1'b1;
    @(posedge clk);
    #1;
    check("t1 busy after start", 32'(bus.busy), 32'h1);
    for (int i = 0; i < 4; i++) strobe(i == 2 ? 1'b0 : 1'b1, 0);
    strobe(1'b1, 0);
    strobe(1'b1, 0);
    check("t1 data_valid", 32'(bus.data_valid), 32'h1);
    check("t1 data_out",   32'(bus.data_out),   32'hB);
    check("t1 parity_err", 32'(bus.parity_err), 32'h0);
    check("t1 err_cnt",    32'(bus.err_cnt),    32'h0);
    check("t1 busy end",   32'(bus.busy),       32'h0);
    idle_cycle();
    check("t1 valid drop", 32'(bus.data_valid), 32'h0);

    // 2: word B with wrong parity bit
    frame(4'hB, 1'b0, 1'b1, 0);
    check("t2 data_valid", 32'(bus.data_valid), 32'h1);
    check("t2 data_out",   32'(bus.data_out),   32'hB);
    check("t2 parity_err", 32'(bus.parity_err), 32'h1);
    check("t2 err_cnt",    32'(bus.err_cnt),    32'h1);
    idle_cycle();

    // 3: word 3 with stop bit 0
    frame(4'h3, 1'b0, 1'b0, 0);
    check("t3 frame_err",  32'(bus.frame_err),  32'h1);
    check("t3 data_valid", 32'(bus.data_valid), 32'h0);
    check("t3 data_out",   32'(bus.data_out),   32'hB);
    check("t3 err_cnt",    32'(bus.err_cnt),    32'h1);
    check("t3 parity_err", 32'(bus.parity_err), 32'h1);
    idle_cycle();
    check("t3 frame_err drop", 32'(bus.frame_err), 32'h0);

    // 4: reset after two data bits, then word 6
    strobe(1'b0, 0);
    strobe(1'b0, 0);
    strobe(1'b1, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("t4 rst data_out",   32'(bus.data_out),   32'h0);
    check("t4 rst parity_err", 32'(bus.parity_err), 32'h0);
    check("t4 rst err_cnt",    32'(bus.err_cnt),    32'h0);
    check("t4 rst busy",       32'(bus.busy),       32'h0);
    check("t4 rst valid",      32'(bus.data_valid), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("t4 busy post rst", 32'(bus.busy), 32'h0);
    frame(4'h6, 1'b0, 1'b1, 0);
    check("t4 data_valid", 32'(bus.data_valid), 32'h1);
    check("t4 data_out",   32'(bus.data_out),   32'h6);
    check("t4 parity_err", 32'(bus.parity_err), 32'h0);
    idle_cycle();

    // 5: all 16 words, strobe every 3rd cycle, frames back-to-back
    for (int w = 0; w < 16; w++) begin
      logic [3:0] wd;
      wd = 4'(w);
      frame(wd, ^wd, 1'b1, 2);
      check($sformatf("t5 valid %0d", w), 32'(bus.data_valid), 32'h1);
      check($sformatf("t5 data %0d", w),  32'(bus.data_out),   32'(wd));
      check($sformatf("t5 perr %0d", w),  32'(bus.parity_err), 32'h0);
      bit_en = 1'b0;
      @(posedge clk);
      #1;
      check($sformatf("t5 valid drop %0d", w), 32'(bus.data_valid), 32'h0);
      @(posedge clk);
      #1;
    end
    check("t5 err_cnt", 32'(bus.err_cnt), 32'h0);

    // 6: five bad-parity frames; 2-bit counter saturates at 3
    for (int k = 0; k < 5; k++) begin
      logic [31:0] exp_sat;
      exp_sat = (k < 3) ? 32'(k + 1) : 32'd3;
      frame(4'h5, 1'b1, 1'b1, 0);
      check($sformatf("t6 sat err_cnt %0d", k), 32'(bus2.err_cnt), exp_sat);
      check($sformatf("t6 sat perr %0d", k), 32'(bus2.parity_err), 32'h1);
      idle_cycle();
    end
    check("t6 wide err_cnt", 32'(bus.err_cnt), 32'h5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule : tb_parity_frame_checker
